// File: rtl/ascii_case_stream.sv
// ascii_case_stream: multi-lane ASCII case converter (pass/upper/lower/toggle per packet) feeding a DEPTH-entry output FIFO.
// Latency: a beat accepted on edge N appears on out_* in cycle N+1 when the FIFO was empty; no combinational in->out path.
// Backpressure: in_ready = (count < DEPTH) from registered state only; out_data/out_last hold while out_valid & !out_ready.
// Optional feature macro: CASE_STATS_EN enables the saturating conv_count statistic (tied to zero otherwise).
module ascii_case_stream #(
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last,
    output logic [15:0]          conv_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = 8 * LANES;
    localparam int W  = DW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      eff_mode;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    rd_word;
    logic [DW-1:0]   conv_data;
    logic            push, pop;

    // Only letters change, by flipping bit 5; every other byte passes through.
    function automatic logic [7:0] conv_char(input logic [7:0] c, input logic [1:0] m);
        logic is_up;
        logic is_lo;
        logic flip;
        is_up = (c >= 8'h41) && (c <= 8'h5A);
        is_lo = (c >= 8'h61) && (c <= 8'h7A);
        case (m)
            2'b01:   flip = is_lo;
            2'b10:   flip = is_up;
            2'b11:   flip = is_up | is_lo;
            default: flip = 1'b0;
        endcase
        return c ^ {2'b00, flip, 5'b00000};
    endfunction

    assign in_ready  = (count_q < (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign rd_word   = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? rd_word[DW-1:0] : '0;
    assign out_last  = out_valid & rd_word[W-1];

    // First beat of a packet uses the live mode; later beats use the latched one.
    always_comb begin
        eff_mode  = (state_q == IDLE) ? mode : mode_q;
        conv_data = '0;
        for (int k = 0; k < LANES; k++) begin
            conv_data[8*k +: 8] = conv_char(in_data[8*k +: 8], eff_mode);
        end
    end

    // Packet FSM next state and mode latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (push) begin
            case (state_q)
                IDLE: begin
                    mode_d  = mode;
                    state_d = in_last ? IDLE : IN_PKT;
                end
                IN_PKT: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy next state; push and pop together keep count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // FIFO control registers and storage of converted {last, data}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {in_last, conv_data};
            end
        end
    end

`ifdef CASE_STATS_EN
    logic [15:0] conv_count_q, conv_count_d;
    logic [15:0] n_changed;
    logic [16:0] conv_sum;

    // Count lanes altered on an accepted beat; saturate instead of wrapping.
    always_comb begin
        n_changed = '0;
        for (int k = 0; k < LANES; k++) begin
            n_changed = n_changed + 16'(conv_data[8*k +: 8] != in_data[8*k +: 8]);
        end
        conv_sum     = {1'b0, conv_count_q} + {1'b0, n_changed};
        conv_count_d = conv_count_q;
        if (push) begin
            conv_count_d = conv_sum[16] ? 16'hFFFF : conv_sum[15:0];
        end
    end

    // Statistic register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count_q <= '0;
        end else begin
            conv_count_q <= conv_count_d;
        end
    end

    assign conv_count = conv_count_q;
`else
    assign conv_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: directed vectors plus random traffic against a queue-based reference.
// Outputs are sampled at the falling edge; inputs are driven at the falling edge.
// Covers reset, modes, boundary bytes, mode latch, backpressure, throughput and async reset.
module tb_ascii_case_stream;

    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] conv_count;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    int          exp_conv = 0;
    logic        m_inpkt  = 1'b0;
    logic [1:0]  m_mode   = 2'b00;

    ascii_case_stream #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [7:0] c, input logic [1:0] m);
        int v;
        bit up, lo;
        v  = int'(c);
        up = (v >= 65) && (v <= 90);
        lo = (v >= 97) && (v <= 122);
        if ((m == 2'd1 || m == 2'd3) && lo) v = v - 32;
        else if ((m == 2'd2 || m == 2'd3) && up) v = v + 32;
        return 8'(v);
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic tick(input logic iv, input logic [1:0] md, input logic [31:0] d,
                        input logic l, input logic ordy, output logic acc);
        logic        m_rdy;
        logic [1:0]  use_mode;
        logic [31:0] cd;
        logic [7:0]  ch;
        int          nchg;
        in_valid  = iv;
        mode      = md;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        m_rdy = (exp_q.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0][31:0]);
            chk("out_last", 32'(out_last), 32'(exp_q[0][32]));
        end else begin
            chk("out_data_idle", out_data, 32'h0);
        end
        chk("conv_count", 32'(conv_count), 32'(exp_conv));
        acc = iv && m_rdy;
        @(posedge clk);
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (acc) begin
            use_mode = m_inpkt ? m_mode : md;
            if (!m_inpkt) m_mode = md;
            m_inpkt = !l;
            nchg = 0;
            for (int k = 0; k < LANES; k++) begin
                ch = ref_char(d[8*k +: 8], use_mode);
                cd[8*k +: 8] = ch;
                if (ch != d[8*k +: 8]) nchg++;
            end
            exp_q.push_back({l, cd});
`ifdef CASE_STATS_EN
            exp_conv = (exp_conv + nchg > 65535) ? 65535 : exp_conv + nchg;
`endif
        end
        @(negedge clk);
    endtask

    // Present a beat until accepted, bounded by a cycle budget.
    task automatic send(input logic [1:0] md, input logic [31:0] d, input logic l, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            tick(1'b1, md, d, l, ordy, acc);
        end
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted data=%h", d);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_conv_count", 32'(conv_count), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // To-upper single-beat packet.
        send(2'b01, 32'h215A6261, 1'b1, 1'b1);
        chk("t1_data", out_data, 32'h215A4241);
        chk("t1_last", 32'(out_last), 32'h1);

        // Toggle mode: boundary bytes unchanged, letters flipped.
        send(2'b11, 32'h7B5B6040, 1'b1, 1'b1);
        chk("t2_boundary", out_data, 32'h7B5B6040);
        send(2'b11, 32'h7A615A41, 1'b1, 1'b1);
        chk("t2_toggle", out_data, 32'h5A417A61);
        idle(2);

        // Mode latched on the first beat of a packet.
        send(2'b10, 32'h44434241, 1'b0, 1'b0);
        send(2'b01, 32'h44434241, 1'b1, 1'b0);
        chk("t3_beat0", out_data, 32'h64636261);
        tick(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        chk("t3_beat1", out_data, 32'h64636261);
        chk("t3_beat1_last", 32'(out_last), 32'h1);
        idle(1);
        send(2'b01, 32'h64636261, 1'b1, 1'b1);
        chk("t3_next_pkt", out_data, 32'h44434241);
        idle(2);

        // Backpressure: four beats fill the FIFO, the fifth waits.
        for (int i = 0; i < 4; i++) send(2'b01, 32'h61626364 + 32'(i), (i == 1), 1'b0);
        chk("t4_full_ready", 32'(in_ready), 32'h0);
        tick(1'b1, 2'b00, 32'h41424344, 1'b1, 1'b0, acc);
        tick(1'b1, 2'b00, 32'h41424344, 1'b1, 1'b0, acc);
        send(2'b00, 32'h41424344, 1'b1, 1'b1);
        idle(6);

        // Steady push/pop with the FIFO half full; pointers wrap repeatedly.
        send(2'b01, $urandom, 1'b0, 1'b0);
        send(2'b01, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0), 1'b1, acc);
            total++;
            assert (acc) else begin
                bad++;
                $error("FAIL t5_throughput observed=stall expected=accept cycle=%0d", i);
            end
        end
        idle(4);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0), acc);
        end
        idle(6);

        // Asynchronous reset mid-packet with three beats queued.
        send(2'b01, 32'h61616161, 1'b0, 1'b0);
        send(2'b01, 32'h62626262, 1'b0, 1'b0);
        send(2'b01, 32'h63636363, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'h0);
        chk("t6_async_data", out_data, 32'h0);
        chk("t6_async_count", 32'(conv_count), 32'h0);
        exp_q.delete();
        exp_conv = 0;
        m_inpkt  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b10, 32'h44434241, 1'b1, 1'b1);
        chk("t6_live_mode", out_data, 32'h64636261);
        idle(2);

`ifdef CASE_STATS_EN
        // Drive the statistic into saturation.
        for (int i = 0; i < 16400; i++) tick(1'b1, 2'b01, 32'h61616161, 1'b1, 1'b1, acc);
        idle(2);
        chk("t6_saturated", 32'(conv_count), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
